// File: rtl/iob_ahb_master.sv
// rtl/iob_ahb_master.sv - IOb native request to AHB-Lite single-transfer manager bridge
// Optional HRESP/iob_err error path is enabled by defining IOB_AHB_MASTER_HRESP_EN.
module iob_ahb_master #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              iob_valid,
    input  logic [ADDR_W-1:0] iob_addr,
    input  logic [DATA_W-1:0] iob_wdata,
    input  logic [3:0]        iob_wstrb,
    output logic              iob_ready,
    output logic              iob_rvalid,
    output logic [DATA_W-1:0] iob_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
`ifdef IOB_AHB_MASTER_HRESP_EN
    ,
    input  logic              HRESP,
    output logic              iob_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [1:0]        state;
    logic [ADDR_W-3:0] word_addr;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        lanes_left;

    logic [2:0] first_size;
    logic [1:0] first_off;
    logic [3:0] first_rest;
    logic [1:0] next_off;
    logic [3:0] next_rest;
    logic       bus_err;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^iob_addr[1:0];

    function automatic logic [1:0] low_lane(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    // Contiguous word/halfword patterns go out in one transfer; anything else
    // becomes a chain of byte writes, lowest lane first.
    always_comb begin
        first_size = 3'b010;
        first_off  = 2'd0;
        first_rest = 4'd0;
        case (iob_wstrb)
            4'b0000, 4'b1111: begin
                first_size = 3'b010;
                first_off  = 2'd0;
            end
            4'b0011: begin
                first_size = 3'b001;
                first_off  = 2'd0;
            end
            4'b1100: begin
                first_size = 3'b001;
                first_off  = 2'd2;
            end
            default: begin
                first_size = 3'b000;
                first_off  = low_lane(iob_wstrb);
                first_rest = iob_wstrb & (iob_wstrb - 4'd1);
            end
        endcase
    end

    assign next_off  = low_lane(lanes_left);
    assign next_rest = lanes_left & (lanes_left - 4'd1);

`ifdef IOB_AHB_MASTER_HRESP_EN
    assign bus_err = HRESP;
`else
    assign bus_err = 1'b0;
`endif

    assign iob_ready = (state == S_IDLE);
    assign HTRANS    = (state == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            word_addr  <= '0;
            wdata_q    <= '0;
            lanes_left <= 4'd0;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= 3'b000;
            HWDATA     <= '0;
            iob_rvalid <= 1'b0;
            iob_rdata  <= '0;
`ifdef IOB_AHB_MASTER_HRESP_EN
            iob_err    <= 1'b0;
`endif
        end else begin
            iob_rvalid <= 1'b0;
`ifdef IOB_AHB_MASTER_HRESP_EN
            iob_err    <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (iob_valid) begin
                        word_addr  <= iob_addr[ADDR_W-1:2];
                        wdata_q    <= iob_wdata;
                        lanes_left <= first_rest;
                        HADDR      <= {iob_addr[ADDR_W-1:2], first_off};
                        HSIZE      <= first_size;
                        HWRITE     <= |iob_wstrb;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        HWDATA <= wdata_q;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        if (!HWRITE) begin
                            iob_rvalid <= 1'b1;
                            iob_rdata  <= bus_err ? '0 : HRDATA;
                        end
`ifdef IOB_AHB_MASTER_HRESP_EN
                        iob_err <= HRESP;
`endif
                        // An error response abandons any byte lanes still queued.
                        if ((lanes_left != 4'd0) && !bus_err) begin
                            HADDR      <= {word_addr, next_off};
                            HSIZE      <= 3'b000;
                            lanes_left <= next_rest;
                            state      <= S_ADDR;
                        end else begin
                            lanes_left <= 4'd0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_ahb_master.sv
// tb/tb_iob_ahb_master.sv - self-checking bench for iob_ahb_master against a request-level model
module tb_iob_ahb_master;

    localparam int ADDR_W = 14;
    localparam int WORDS  = 1 << (ADDR_W - 2);

    logic              HCLK;
    logic              HRESETn;
    logic              iob_valid;
    logic [ADDR_W-1:0] iob_addr;
    logic [31:0]       iob_wdata;
    logic [3:0]        iob_wstrb;
    logic              iob_ready;
    logic              iob_rvalid;
    logic [31:0]       iob_rdata;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
`ifdef IOB_AHB_MASTER_HRESP_EN
    logic              HRESP;
    logic              iob_err;
`endif

    iob_ahb_master #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .iob_valid (iob_valid),
        .iob_addr  (iob_addr),
        .iob_wdata (iob_wdata),
        .iob_wstrb (iob_wstrb),
        .iob_ready (iob_ready),
        .iob_rvalid(iob_rvalid),
        .iob_rdata (iob_rdata),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY)
`ifdef IOB_AHB_MASTER_HRESP_EN
        ,
        .HRESP     (HRESP),
        .iob_err   (iob_err)
`endif
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int total;
    int bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [2:0]        s;
        logic              w;
    } xfer_t;

    xfer_t       addr_log[$];
    logic [31:0] ref_mem  [WORDS];
    logic [31:0] slave_mem[WORDS];
    logic        err_arm;
    logic        rand_mode;
    int          forced_waits;

    // Subordinate: RAM with programmable wait states and optional two-cycle error.
    logic              sl_dphase, sl_write, sl_err, nrdy, nresp, clear_err;
    logic [ADDR_W-1:0] sl_addr;
    logic [2:0]        sl_size;
    logic [31:0]       nrd;
    int                waits;

    initial begin
        HREADY = 1'b1;
        HRDATA = '0;
`ifdef IOB_AHB_MASTER_HRESP_EN
        HRESP  = 1'b0;
`endif
        sl_dphase = 0; sl_write = 0; sl_err = 0; sl_addr = '0; sl_size = '0; waits = 0;
        forever begin
            @(negedge HCLK);
            clear_err = 0;
            nresp     = 0;
            if (!HRESETn) begin
                sl_dphase = 0; sl_err = 0; nrdy = 1; nrd = $urandom;
            end else begin
                if (sl_dphase && HREADY) begin
                    if (sl_write && !sl_err) begin
                        for (int i = 0; i < 4; i++) begin
                            if ((sl_size == 3'd2) ||
                                (sl_size == 3'd1 && (i >> 1) == int'(sl_addr[1])) ||
                                (sl_size == 3'd0 && i == int'(sl_addr[1:0])))
                                slave_mem[sl_addr[ADDR_W-1:2]][8*i +: 8] = HWDATA[8*i +: 8];
                        end
                    end
                    sl_dphase = 0; sl_err = 0;
                end
                if (HTRANS == 2'b10 && HREADY) begin
                    sl_dphase = 1; sl_addr = HADDR; sl_size = HSIZE; sl_write = HWRITE;
                    sl_err = err_arm;
                    if (err_arm) begin
                        waits = 1; clear_err = 1;
                    end else begin
                        waits = rand_mode ? $urandom_range(0, 2) : forced_waits;
                    end
                end
                if (sl_dphase) begin
                    nrdy = (waits == 0);
                    if (waits > 0) waits--;
                    nresp = sl_err;
                    nrd = sl_write ? $urandom : slave_mem[sl_addr[ADDR_W-1:2]];
                end else begin
                    nrdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                    nrd  = $urandom;
                end
            end
            @(posedge HCLK);
            #1;
            HREADY = nrdy;
            HRDATA = nrd;
`ifdef IOB_AHB_MASTER_HRESP_EN
            HRESP  = nresp;
`endif
            if (clear_err) err_arm = 0;
        end
    end

    // Request-level model: each request expands into its transfer list and
    // occupies 2 bus phases per transfer; HREADY=0 cycles stall the phase count.
    int                m_total, m_left, m_p, m_n;
    logic [ADDR_W-1:0] xa[4];
    logic [2:0]        xs[4];
    logic [ADDR_W-1:0] ma;
    logic              xw, xerr, resp_pend, err_pend;
    logic [31:0]       xd, xrd, resp_data;

    initial begin
        m_left = 0; m_total = 0; resp_pend = 0; err_pend = 0; resp_data = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                chk("rst_ready",  iob_ready,  1);
                chk("rst_htrans", HTRANS,     0);
                chk("rst_rvalid", iob_rvalid, 0);
                chk("rst_rdata",  iob_rdata,  0);
                chk("rst_haddr",  HADDR,      0);
                chk("rst_hwrite", HWRITE,     0);
                chk("rst_hsize",  HSIZE,      0);
                chk("rst_hwdata", HWDATA,     0);
`ifdef IOB_AHB_MASTER_HRESP_EN
                chk("rst_err",    iob_err,    0);
`endif
                m_left = 0; resp_pend = 0; err_pend = 0;
            end else begin
                chk("ready",  iob_ready,  m_left == 0);
                chk("rvalid", iob_rvalid, resp_pend);
                if (resp_pend) chk("rdata", iob_rdata, resp_data);
`ifdef IOB_AHB_MASTER_HRESP_EN
                chk("err", iob_err, err_pend);
`endif
                chk("hburst", HBURST, 3'b000);
                chk("hprot",  HPROT,  4'b0011);
                if (m_left > 0) begin
                    m_p = m_total - m_left;
                    if (m_p % 2 == 0) begin
                        chk("htrans_addr", HTRANS, 2'b10);
                        chk("haddr",  HADDR,  xa[m_p/2]);
                        chk("hsize",  HSIZE,  xs[m_p/2]);
                        chk("hwrite", HWRITE, xw);
                    end else begin
                        chk("htrans_data", HTRANS, 2'b00);
                        if (xw) chk("hwdata", HWDATA, xd);
                    end
                end else begin
                    chk("htrans_idle", HTRANS, 2'b00);
                end
                if (HTRANS == 2'b10 && HREADY) addr_log.push_back('{a: HADDR, s: HSIZE, w: HWRITE});

                resp_pend = 0; err_pend = 0;
                if (m_left > 0) begin
                    if (HREADY) begin
                        m_left--;
                        if (m_left == 0) begin
                            resp_pend = !xw;
                            err_pend  = xerr;
                            resp_data = xerr ? 32'h0 : xrd;
                        end
                    end
                end else if (iob_valid) begin
                    ma = {iob_addr[ADDR_W-1:2], 2'b00};
                    xw = (iob_wstrb != 4'b0000); xd = iob_wdata; xerr = err_arm; m_n = 0;
                    case (iob_wstrb)
                        4'b0000, 4'b1111: begin xa[0] = ma;                xs[0] = 3'd2; m_n = 1; end
                        4'b0011:          begin xa[0] = ma;                xs[0] = 3'd1; m_n = 1; end
                        4'b1100:          begin xa[0] = ma + ADDR_W'(2);   xs[0] = 3'd1; m_n = 1; end
                        default: begin
                            for (int i = 0; i < 4; i++) begin
                                if (iob_wstrb[i]) begin
                                    xa[m_n] = ma + ADDR_W'(i); xs[m_n] = 3'd0; m_n++;
                                end
                            end
                        end
                    endcase
                    m_total = xerr ? 2 : 2 * m_n;
                    m_left  = m_total;
                    xrd = ref_mem[ma[ADDR_W-1:2]];
                    if (xw && !xerr) begin
                        for (int i = 0; i < 4; i++)
                            if (iob_wstrb[i]) ref_mem[ma[ADDR_W-1:2]][8*i +: 8] = iob_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [ADDR_W-1:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic rv, output logic er);
        int n;
        @(posedge HCLK);
        #1;
        addr_log.delete();
        iob_valid = 1; iob_addr = a; iob_wstrb = s; iob_wdata = d;
        n = 0;
        do begin @(negedge HCLK); n++; end while (!iob_ready && n < 50);
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        @(posedge HCLK);
        #1;
        iob_valid = 0; iob_addr = ADDR_W'($urandom); iob_wdata = $urandom; iob_wstrb = 4'($urandom);
        lat = 0;
        do begin @(negedge HCLK); lat++; end while (!iob_ready && lat < 60);
        if (lat >= 60) begin
            total++; bad++;
            $display("FAIL done_timeout: got ready=0 expected ready=1 within 60 cycles");
        end
        rv = iob_rvalid; rd = iob_rdata;
`ifdef IOB_AHB_MASTER_HRESP_EN
        er = iob_err;
`else
        er = 1'b0;
`endif
    endtask

    int          lat;
    logic [31:0] rd;
    logic        rv, er;

    initial begin
        total = 0; bad = 0;
        err_arm = 0; rand_mode = 0; forced_waits = 0;
        for (int i = 0; i < WORDS; i++) begin
            ref_mem[i] = '0; slave_mem[i] = '0;
        end
        HRESETn = 0; iob_valid = 0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1;
        repeat (2) @(posedge HCLK);

        do_req(14'h010, 4'b1111, 32'hDEADBEEF, lat, rd, rv, er);
        chk("wr_word_lat", lat, 3);
        chk("wr_word_nxfer", addr_log.size(), 1);
        if (addr_log.size() > 0) chk("wr_word_xfer", addr_log[0], {14'h010, 3'b010, 1'b1});
        chk("wr_word_rv", rv, 0);

        do_req(14'h010, 4'b0000, 32'h0, lat, rd, rv, er);
        chk("rd_lat", lat, 3);
        chk("rd_rv", rv, 1);
        chk("rd_data", rd, 32'hDEADBEEF);

        do_req(14'h020, 4'b0100, 32'h11223344, lat, rd, rv, er);
        chk("wr_b2_nxfer", addr_log.size(), 1);
        if (addr_log.size() > 0) chk("wr_b2_xfer", addr_log[0], {14'h022, 3'b000, 1'b1});

        do_req(14'h020, 4'b1100, 32'hAABBCCDD, lat, rd, rv, er);
        chk("wr_h2_nxfer", addr_log.size(), 1);
        if (addr_log.size() > 0) chk("wr_h2_xfer", addr_log[0], {14'h022, 3'b001, 1'b1});

        do_req(14'h020, 4'b0000, 32'h0, lat, rd, rv, er);
        chk("rd_lanes", rd, 32'hAABB0000);

        do_req(14'h030, 4'b1011, 32'h01020304, lat, rd, rv, er);
        chk("split_lat", lat, 7);
        chk("split_nxfer", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            chk("split_x0", addr_log[0], {14'h030, 3'b000, 1'b1});
            chk("split_x1", addr_log[1], {14'h031, 3'b000, 1'b1});
            chk("split_x2", addr_log[2], {14'h033, 3'b000, 1'b1});
        end
        do_req(14'h030, 4'b0000, 32'h0, lat, rd, rv, er);
        chk("split_rd", rd, 32'h01000304);

        forced_waits = 2;
        do_req(14'h010, 4'b0000, 32'h0, lat, rd, rv, er);
        forced_waits = 0;
        chk("wait_lat", lat, 5);
        chk("wait_data", rd, 32'hDEADBEEF);

        // Reset asserted while a read sits in its data phase.
        forced_waits = 3;
        @(posedge HCLK);
        #1 iob_valid = 1; iob_addr = 14'h010; iob_wstrb = 4'b0000;
        @(negedge HCLK);
        @(posedge HCLK);
        #1 iob_valid = 0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("pre_rst_htrans", HTRANS, 2'b00);
        chk("pre_rst_ready", iob_ready, 0);
        @(posedge HCLK);
        #1 HRESETn = 0;
        @(negedge HCLK);
        chk("mid_rst_htrans", HTRANS, 2'b00);
        chk("mid_rst_ready", iob_ready, 1);
        @(posedge HCLK);
        #1 HRESETn = 1; forced_waits = 0;
        repeat (6) begin
            @(negedge HCLK);
            chk("post_rst_rvalid", iob_rvalid, 0);
        end

`ifdef IOB_AHB_MASTER_HRESP_EN
        err_arm = 1;
        do_req(14'h010, 4'b0000, 32'h0, lat, rd, rv, er);
        chk("err_rd_lat", lat, 4);
        chk("err_rd_rv", rv, 1);
        chk("err_rd_err", er, 1);
        chk("err_rd_data", rd, 32'h0);
        err_arm = 1;
        do_req(14'h040, 4'b1111, 32'hCAFEF00D, lat, rd, rv, er);
        chk("err_wr_rv", rv, 0);
        chk("err_wr_err", er, 1);
        do_req(14'h040, 4'b0000, 32'h0, lat, rd, rv, er);
        chk("err_wr_nochange", rd, 32'h0);
`endif

        // Random back-to-back traffic with random wait states.
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge HCLK);
            #1;
            iob_valid = ($urandom_range(0, 2) != 0);
            iob_addr  = ADDR_W'($urandom_range(0, 255));
            iob_wdata = $urandom;
            iob_wstrb = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        end
        @(posedge HCLK);
        #1 iob_valid = 0; rand_mode = 0;
        repeat (20) @(negedge HCLK);
        for (int i = 0; i < 64; i++) chk("mem_final", slave_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_ahb_master.md
# iob_ahb_master

- Bridges the IOb native request interface (valid/ready, strobed writes) to an AHB-Lite manager port.
- Drives single, non-burst transfers into AHB-Lite subordinates such as the on-chip AHB RAM; sits directly upstream of that RAM.
- Translates write strobes into HSIZE/HADDR[1:0]. Non-contiguous strobes are split into byte transfers.
- Returns read data on a registered response strobe.

## Interface
Parameters:
- ADDR_W, 14, byte-address width of iob_addr and HADDR.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- HCLK  in  1  single clock, rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- iob_valid  in  1  request valid.
- iob_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- iob_wdata  in  32  write data, lane-aligned.
- iob_wstrb  in  4  byte strobes; 0 = read.
- iob_ready  out  1  request accepted when valid&ready at clock edge.
- iob_rvalid  out  1  one-cycle read-data strobe.
- iob_rdata  out  32  read data, valid while iob_rvalid=1.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  000 byte, 001 half, 010 word.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HWDATA  out  32  write data during data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  bus ready (subordinate HREADYOUT).
- HRESP  in  1  only with IOB_AHB_MASTER_HRESP_EN.
- iob_err  out  1  only with IOB_AHB_MASTER_HRESP_EN.

## Operation
- FSM with three states: IDLE, ADDR, DATA.
- Reset values: state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, iob_ready=1, iob_rvalid=0, iob_rdata=0, iob_err=0.
- **IDLE**
  - iob_ready=1.
  - On valid&ready: latch addr, wdata, wstrb; go to ADDR.
- **ADDR**
  - HTRANS=NONSEQ; HADDR, HWRITE, HSIZE registered from the latched request.
  - Stays in ADDR while HREADY=0.
  - HREADY=1 at the edge: go to DATA.
- **DATA**
  - HTRANS=IDLE; HWDATA=latched wdata.
  - Stays in DATA while HREADY=0.
  - HREADY=1 at the edge: a read captures HRDATA into iob_rdata and pulses iob_rvalid next cycle.
  - Next state is IDLE, or ADDR if split lanes remain.
- **Strobe mapping** (HADDR[1:0] shown):
  - 1111 → word, 00.
  - 0011 → half, 00.
  - 1100 → half, 10.
  - Single-bit strobe → byte at lane index.
  - 0000 → word read, 00.
  - Any other non-zero pattern → one byte write per set lane, ascending lane order, each a full ADDR+DATA pair.
- HWDATA is always the full latched word; the subordinate selects lanes.
- iob_ready stays 0 from acceptance until the final DATA phase completes.
- Writes produce no iob_rvalid.
- iob_wdata, iob_addr and iob_wstrb are ignored when not accepted.

## Timing
- Accept at edge E0 → address phase in cycle after E0 → data phase after E1 (HREADY=1) → completion at E2.
- Read with zero wait states: iob_rvalid=1 in the cycle after E2, 3 cycles after acceptance. Each HREADY=0 cycle adds 1.
- Write with zero wait states: iob_ready returns to 1 in the cycle after E2.
- Throughput is one transfer per 3 cycles.
- A new request is accepted in the same cycle iob_rvalid is high, so back-to-back operation is allowed.
- No address/data overlap: HTRANS is always IDLE during a data phase.
- Split write of n lanes: iob_ready low for 2n cycles plus wait states.
- HRESETn low at any time:
  - Immediate return to reset values; the in-flight request is dropped with no rvalid.
  - iob_ready=1 after release.

## Configuration
IOB_AHB_MASTER_HRESP_EN.

With the macro defined:
- HRESP and iob_err ports exist.
- On HRESP=1 with HREADY=1 ending a DATA phase:
  - iob_err pulses 1 cycle, coincident with iob_rvalid for reads (iob_rdata=0), or alone for writes.
  - Remaining split lanes are abandoned and the FSM goes to IDLE.
- During the first error cycle (HRESP=1, HREADY=0), HTRANS stays IDLE.

Without the macro:
- Both ports are absent.
- Every transfer is treated as OKAY.

## Test plan
- Write addr 0x10, wstrb 1111, data 0xDEADBEEF, HREADY=1 → one cycle HTRANS=10, HADDR=0x10, HSIZE=010, HWRITE=1; next cycle HWDATA=0xDEADBEEF; iob_ready=1 three cycles after acceptance.
- Read addr 0x10 after the previous write → iob_rvalid=1 three cycles after acceptance, iob_rdata=0xDEADBEEF.
- Strobe mapping at addr 0x20:
  - wstrb 0100 → HADDR=0x22, HSIZE=000.
  - wstrb 1100 → HADDR=0x22, HSIZE=001.
  - Readback of word 0x20 shows only those lanes changed.
- wstrb 1011 at addr 0x30 → three byte NONSEQ transfers, HADDR 0x30, 0x31, 0x33; iob_ready low 6 cycles.
- Read with HREADY held 0 for 2 cycles in DATA → iob_rvalid at cycle 5 after acceptance, data correct.
- HRESETn pulsed low during DATA → HTRANS=00 and iob_ready=1 immediately, no iob_rvalid.
- With the macro, two-cycle ERROR response on a read → iob_err and iob_rvalid pulse together, iob_rdata=0.
